cfg_chain_loader: RTL and testbench

- Configuration-side driver for the CLB programming scan chain.
- Accepts bitstream words over a valid/ready stream and serialises them LSB-first onto prog_in, qualified by prog_en, for exactly CHAIN_LEN shift cycles.
- Optionally re-circulates the chain once through prog_out → prog_in to verify the loaded image by CRC, leaving the configuration intact.
- Sits between the bitstream source (host/ROM reader) and the head of the daisy-chained CLB prog_in/prog_out chain; shares prog_clk with the chain.

---
 rtl/cfg_pkg.sv | 20 ++
 rtl/cfg_crc8_serial.sv | 23 ++
 rtl/cfg_chain_loader.sv | 151 +++++++++++++++
 tb/tb_cfg_chain_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared state encoding and CRC-8 helpers for the chain loader
package cfg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } cfg_state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
      logic fb;
      fb = crc[7] ^ bit_in;
      return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/cfg_crc8_serial.sv
// rtl/cfg_crc8_serial.sv - bit-serial CRC-8 accumulator with clear and enable
module cfg_crc8_serial
   import cfg_pkg::*;
(
   input  logic       prog_clk,
   input  logic       rst,
   input  logic       en,
   input  logic       clr,
   input  logic       bit_in,
   output logic [7:0] crc
);

   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         crc <= CRC8_INIT;
      end else if (clr) begin
         crc <= CRC8_INIT;
      end else if (en) begin
         crc <= crc8_step(crc, bit_in);
      end
   end

endmodule

// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - serialises bitstream words onto the CLB scan chain and CRC-verifies it
module cfg_chain_loader
   import cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 17,
   parameter int WORD_W    = 8,
   parameter int VERIFY_EN = 1
) (
   input  logic              prog_clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              prog_in,
   output logic              prog_en,
   input  logic              prog_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              error
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

   cfg_state_t        state, state_nxt;
   logic [WORD_W-1:0] word_buf;
   logic              buf_full;
   logic [IDX_W-1:0]  idx;
   logic [CNT_W-1:0]  bit_cnt;
   logic [7:0]        crc_load, crc_vfy;

   logic shift_load, chain_full, buf_last, accept, crc_clr;

   assign shift_load = (state == LOAD) && buf_full;
   assign chain_full = (bit_cnt == LAST_BIT);
   // The final word is cut short once the chain is full; its spare bits are dropped.
   assign buf_last   = (idx == LAST_IDX) || chain_full;
   assign accept     = cfg_valid && cfg_ready;
   assign crc_clr    = (state == IDLE) && start;

   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    if (shift_load && chain_full) state_nxt = (VERIFY_EN != 0) ? VERIFY : DONE;
         VERIFY:  if (chain_full) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cfg_ready = 1'b0;
      prog_en   = 1'b0;
      prog_in   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         LOAD: begin
            busy      = 1'b1;
            cfg_ready = !buf_full || (buf_last && !chain_full);
            prog_en   = buf_full;
            prog_in   = buf_full && word_buf[idx];
         end
         VERIFY: begin
            busy    = 1'b1;
            prog_en = 1'b1;
            prog_in = prog_out;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         word_buf <= '0;
         buf_full <= 1'b0;
         idx      <= '0;
         bit_cnt  <= '0;
         pass     <= 1'b0;
         error    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  buf_full <= 1'b0;
                  idx      <= '0;
                  bit_cnt  <= '0;
                  pass     <= 1'b0;
                  error    <= 1'b0;
               end
            end
            LOAD: begin
               if (shift_load) begin
                  // bit_cnt is reused as the recirculation counter, so it restarts here.
                  bit_cnt <= chain_full ? '0 : bit_cnt + CNT_W'(1);
                  if (buf_last) begin
                     buf_full <= 1'b0;
                     idx      <= '0;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
               if (accept) begin
                  word_buf <= cfg_data;
                  buf_full <= 1'b1;
                  idx      <= '0;
               end
            end
            VERIFY: bit_cnt <= bit_cnt + CNT_W'(1);
            DONE: begin
               pass  <= (VERIFY_EN != 0) && (crc_vfy == crc_load);
               error <= (VERIFY_EN != 0) && (crc_vfy != crc_load);
            end
            default: ;
         endcase
      end
   end

   cfg_crc8_serial u_crc_load (
      .prog_clk (prog_clk),
      .rst      (rst),
      .en       (shift_load),
      .clr      (crc_clr),
      .bit_in   (prog_in),
      .crc      (crc_load)
   );

   cfg_crc8_serial u_crc_vfy (
      .prog_clk (prog_clk),
      .rst      (rst),
      .en       (state == VERIFY),
      .clr      (crc_clr),
      .bit_in   (prog_out),
      .crc      (crc_vfy)
   );

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb/tb_cfg_chain_loader.sv - self-checking bench for cfg_chain_loader with a 17-bit chain model
module tb_cfg_chain_loader;

   logic prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   logic       rst, start, cfg_valid, cfg_ready, prog_in, prog_en, prog_out, busy, done, pass, error;
   logic [7:0] cfg_data;
   logic       start2, valid2, ready2, pin2, pen2, pout2, busy2, done2, pass2, err2;
   logic [7:0] data2;

   cfg_chain_loader #(.CHAIN_LEN(17), .WORD_W(8), .VERIFY_EN(1)) dut (
      .prog_clk (prog_clk), .rst (rst), .start (start), .cfg_data (cfg_data),
      .cfg_valid (cfg_valid), .cfg_ready (cfg_ready), .prog_in (prog_in), .prog_en (prog_en),
      .prog_out (prog_out), .busy (busy), .done (done), .pass (pass), .error (error)
   );

   cfg_chain_loader #(.CHAIN_LEN(17), .WORD_W(8), .VERIFY_EN(0)) dut_nv (
      .prog_clk (prog_clk), .rst (rst), .start (start2), .cfg_data (data2),
      .cfg_valid (valid2), .cfg_ready (ready2), .prog_in (pin2), .prog_en (pen2),
      .prog_out (pout2), .busy (busy2), .done (done2), .pass (pass2), .error (err2)
   );

   // Chain model: head takes prog_in, tail bit is prog_out; optional one-shot bit-8 upset.
   logic [16:0] chain  = '0;
   logic [16:0] chain2 = '0;
   int unsigned sh_cnt = 0;
   int unsigned inj_target = 0;
   assign prog_out = chain[0];
   assign pout2    = chain2[0];

   always @(posedge prog_clk) begin
      if (prog_en) begin
         chain  <= {prog_in, chain[16:1]} ^ ((sh_cnt + 1 == inj_target) ? 17'h00100 : 17'h00000);
         sh_cnt <= sh_cnt + 1;
      end
      if (pen2) chain2 <= {pin2, chain2[16:1]};
   end

   int unsigned en_tot = 0, stall_tot = 0, done_tot = 0;
   always @(negedge prog_clk) begin
      if (prog_en) en_tot++;
      if (busy && !prog_en) stall_tot++;
      if (done) done_tot++;
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0]  w0, w1, w2;
      int          g0, g1, g2;
      bit          inj, poke, idle_v;
      logic [16:0] exp_chain;
      bit          exp_pass, exp_err;
   } vec_t;

   task automatic feed_word(input logic [7:0] w, input int gap, input string tag);
      int n = 0;
      cfg_valid = 1'b0;
      while (!cfg_ready && n < 100) begin
         @(posedge prog_clk); #1;
         n++;
      end
      chk($sformatf("%s_ready", tag), cfg_ready, 1);
      repeat (gap) begin
         @(posedge prog_clk); #1;
      end
      cfg_valid = 1'b1;
      cfg_data  = w;
      @(posedge prog_clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic run_load(input vec_t v, input string tag);
      int unsigned en0, st0, dn0;
      int n = 0;
      if (v.idle_v) begin
         cfg_valid = 1'b1;
         cfg_data  = 8'hFF;
         repeat (3) begin
            @(posedge prog_clk); #1;
            chk($sformatf("%s_idle_ready", tag), cfg_ready, 0);
         end
         cfg_valid = 1'b0;
      end
      en0 = en_tot; st0 = stall_tot; dn0 = done_tot;
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
      if (v.inj) inj_target = sh_cnt + 17;
      feed_word(v.w0, v.g0, tag);
      if (v.poke) begin
         start = 1'b1;
         @(posedge prog_clk); #1;
         start = 1'b0;
      end
      feed_word(v.w1, v.g1, tag);
      feed_word(v.w2, v.g2, tag);
      while (!done && n < 200) begin
         @(posedge prog_clk); #1;
         n++;
      end
      chk($sformatf("%s_done_seen", tag), done, 1);
      @(posedge prog_clk); #1;
      inj_target = 0;
      chk($sformatf("%s_chain", tag), chain, v.exp_chain);
      chk($sformatf("%s_pass", tag), pass, v.exp_pass);
      chk($sformatf("%s_error", tag), error, v.exp_err);
      chk($sformatf("%s_en_cycles", tag), en_tot - en0, 34);
      chk($sformatf("%s_stalls", tag), stall_tot - st0, 1 + v.g0 + v.g1 + v.g2);
      chk($sformatf("%s_done_pulses", tag), done_tot - dn0, 1);
      chk($sformatf("%s_idle_busy", tag), busy, 0);
   endtask

   initial begin
      vec_t        vecs[7];
      vec_t        rv;
      logic [23:0] img;
      logic [7:0]  nv_words[3];
      int unsigned base;
      int          wi, en_n, dn_n, last_en, dn_cyc;
      bit          acc;

      rst = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
      start2 = 1'b0; valid2 = 1'b0; data2 = '0;
      @(posedge prog_clk); #1;
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_prog_en", prog_en, 0);
      chk("rst_prog_in", prog_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass_error", {pass, error}, 0);
      chk("rst_nv_outputs", {ready2, pen2, pin2, busy2, done2, pass2, err2}, 0);
      @(posedge prog_clk); #1;
      rst = 1'b1;
      @(posedge prog_clk); #1;

      vecs[0] = '{8'hA5, 8'h3C, 8'h01, 0, 0, 0, 1'b0, 1'b0, 1'b0, 17'h13CA5, 1'b1, 1'b0};
      vecs[1] = '{8'hA5, 8'h3C, 8'h01, 0, 0, 5, 1'b0, 1'b0, 1'b0, 17'h13CA5, 1'b1, 1'b0};
      vecs[2] = '{8'hA5, 8'h3C, 8'h01, 0, 0, 0, 1'b1, 1'b0, 1'b0, 17'h13DA5, 1'b0, 1'b1};
      vecs[3] = '{8'hA5, 8'h3C, 8'h01, 0, 0, 0, 1'b0, 1'b1, 1'b1, 17'h13CA5, 1'b1, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 8'h01, 0, 0, 0, 1'b0, 1'b0, 1'b0, 17'h1FFFF, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 8'hFE, 0, 0, 0, 1'b0, 1'b0, 1'b0, 17'h00000, 1'b1, 1'b0};
      vecs[6] = '{8'h5A, 8'hC3, 8'hFF, 1, 2, 0, 1'b0, 1'b0, 1'b0, 17'h1C35A, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) run_load(vecs[i], $sformatf("vec%0d", i));

      // Reset after 10 load shifts, then a fresh load must work.
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
      base = sh_cnt;
      feed_word(8'hA5, 0, "rstseq");
      feed_word(8'h3C, 0, "rstseq");
      repeat (2) @(posedge prog_clk);
      #1;
      chk("rstseq_shifts", sh_cnt - base, 10);
      rst = 1'b0;
      #1;
      chk("rstseq_prog_en", prog_en, 0);
      chk("rstseq_busy", busy, 0);
      chk("rstseq_cfg_ready", cfg_ready, 0);
      chk("rstseq_pass_error", {pass, error}, 0);
      @(posedge prog_clk); #1;
      rst = 1'b1;
      @(posedge prog_clk); #1;
      run_load('{8'hFF, 8'hFF, 8'h01, 0, 0, 0, 1'b0, 1'b0, 1'b0, 17'h1FFFF, 1'b1, 1'b0}, "rstseq_reload");

      // Random words and source gaps; expected image is the first 17 bits of the word stream.
      for (int k = 0; k < 6; k++) begin
         rv.w0 = 8'($urandom); rv.w1 = 8'($urandom); rv.w2 = 8'($urandom);
         rv.g0 = $urandom_range(0, 3); rv.g1 = $urandom_range(0, 3); rv.g2 = $urandom_range(0, 3);
         rv.inj = 1'b0; rv.poke = 1'b0; rv.idle_v = 1'b0;
         img = {rv.w2, rv.w1, rv.w0};
         rv.exp_chain = img[16:0];
         rv.exp_pass = 1'b1; rv.exp_err = 1'b0;
         run_load(rv, $sformatf("rnd%0d", k));
      end

      // VERIFY_EN=0: exactly 17 shifts, done the cycle after the last one, no verdict.
      nv_words[0] = 8'hA5; nv_words[1] = 8'h3C; nv_words[2] = 8'h01;
      wi = 0; en_n = 0; dn_n = 0; last_en = -1; dn_cyc = -2;
      start2 = 1'b1;
      @(posedge prog_clk); #1;
      start2 = 1'b0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         valid2 = (wi < 3);
         if (wi < 3) data2 = nv_words[wi];
         if (pen2) begin en_n++; last_en = cyc; end
         if (done2) begin dn_n++; dn_cyc = cyc; end
         acc = valid2 && ready2;
         @(posedge prog_clk); #1;
         if (acc) wi++;
      end
      valid2 = 1'b0;
      chk("nv_en_cycles", en_n, 17);
      chk("nv_done_pulses", dn_n, 1);
      chk("nv_done_timing", dn_cyc, last_en + 1);
      chk("nv_chain", chain2, 17'h13CA5);
      chk("nv_pass", pass2, 0);
      chk("nv_error", err2, 0);
      chk("nv_busy", busy2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
